// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer SRAM master.
package fb_pkg;

   localparam int FB_ADDR_W     = 15;
   localparam int FB_DATA_W     = 8;
   localparam int FB_FIFO_DEPTH = 4;
   localparam int FB_LINE_BYTES = 40;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4
   } fb_state_e;

   // The block owns the SRAM data bus in exactly these states.
   function automatic logic fb_is_wr_state(input fb_state_e s);
      return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
   endfunction

endpackage

// File: rtl/fb_sram_master_if.sv
// CPU write port, line/scanout handshake and SRAM strobe/address bundle.
interface fb_sram_master_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
);

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              line_start;
   logic [ADDR_W-1:0] line_base;
   logic              pix_valid;
   logic              pix_rdy;
   logic [DATA_W-1:0] pix_data;
   logic              line_busy;
   logic [ADDR_W-1:0] sram_a;
   logic              sram_cs_n;
   logic              sram_oe_n;
   logic              sram_we_n;

   modport master (
      input  wr_req, wr_addr, wr_data, line_start, line_base, pix_rdy,
      output wr_ack, pix_valid, pix_data, line_busy,
      output sram_a, sram_cs_n, sram_oe_n, sram_we_n
   );

   modport slave (
      output wr_req, wr_addr, wr_data, line_start, line_base, pix_rdy,
      input  wr_ack, pix_valid, pix_data, line_busy,
      input  sram_a, sram_cs_n, sram_oe_n, sram_we_n
   );

endinterface

// File: rtl/fb_line_fifo.sv
// Scanout prefetch FIFO with synchronous flush; head is presented combinationally.
// Push completes in one cycle; a push while full is dropped (the caller never issues one).
module fb_line_fifo
   import fb_pkg::*;
#(
   parameter int DATA_W = FB_DATA_W,
   parameter int DEPTH  = FB_FIFO_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [DATA_W-1:0]            i_push_dat,
   input  logic                         i_pop,
   output logic                         o_vld,
   output logic [DATA_W-1:0]            o_dat,
   output logic [$clog2(DEPTH):0]       o_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_cnt;
   logic              w_push;
   logic              w_pop;

   assign w_push = i_push && (r_cnt != CW'(DEPTH));
   assign w_pop  = i_pop && (r_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push && !i_flush) begin
         r_mem[r_wptr] <= i_push_dat;
      end
   end

   assign o_vld = (r_cnt != '0);
   assign o_dat = r_mem[r_rptr];
   assign o_cnt = r_cnt;

endmodule

// File: rtl/fb_sram_master.sv
// Arbitrates CPU byte writes against line scanout reads on an async SRAM; reads are 1 cycle, writes 3 cycles.
// Scanout stalls when the prefetch FIFO would overflow; pix_rdy low only stops the FIFO draining.
module fb_sram_master
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
   parameter int LINE_BYTES = FB_LINE_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fb_sram_master_if.master      bus,
   inout  wire  [DATA_W-1:0]     io_sram_io
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int RW = $clog2(LINE_BYTES + 1);

   fb_state_e          r_state;
   fb_state_e          w_next;
   logic [ADDR_W-1:0]  r_rd_ptr;
   logic [ADDR_W-1:0]  w_rd_ptr_nxt;
   logic [RW-1:0]      r_remaining;
   logic [RW-1:0]      w_rem_nxt;
   logic [ADDR_W-1:0]  r_a;
   logic               r_cs_n;
   logic               r_oe_n;
   logic               r_we_n;
   logic               r_wr_ack;
   logic               r_io_oe;
   logic [DATA_W-1:0]  r_io_dat;

   logic [CW-1:0]      w_fifo_cnt;
   logic [CW-1:0]      w_cnt_base;
   logic               w_fifo_vld;
   logic [DATA_W-1:0]  w_fifo_dat;
   logic               w_rd_done;
   logic               w_push;
   logic               w_pop;
   logic               w_rd_ok;
   logic               w_wr_first;

   assign w_rd_done = (r_state == RD);
   // A read landing in the same cycle as line_start belongs to the old line.
   assign w_push    = w_rd_done && !bus.line_start;
   assign w_pop     = w_fifo_vld && bus.pix_rdy;

   fb_line_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (bus.line_start),
      .i_push     (w_push),
      .i_push_dat (io_sram_io),
      .i_pop      (w_pop),
      .o_vld      (w_fifo_vld),
      .o_dat      (w_fifo_dat),
      .o_cnt      (w_fifo_cnt)
   );

   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr;
      w_rem_nxt    = r_remaining;
      if (bus.line_start) begin
         w_rd_ptr_nxt = bus.line_base;
         w_rem_nxt    = RW'(LINE_BYTES);
      end else if (w_rd_done) begin
         w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
         w_rem_nxt    = r_remaining - RW'(1);
      end
   end

   // Arbitration sees the post-cycle view: remaining after this read, and the
   // read that is completing counted as already occupying a FIFO slot.
   always_comb begin
      w_cnt_base = bus.line_start ? '0 : w_fifo_cnt;
      w_rd_ok    = (w_rem_nxt != '0) &&
                   ((w_cnt_base + CW'(w_push)) < CW'(FIFO_DEPTH));
      w_wr_first = bus.wr_req &&
                   (!w_rd_ok || (w_cnt_base >= CW'(FIFO_DEPTH / 2)));
   end

   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE, RD: begin
            if (w_wr_first)   w_next = WR_SETUP;
            else if (w_rd_ok) w_next = RD;
            else              w_next = IDLE;
         end
         WR_SETUP: w_next = WR_PULSE;
         WR_PULSE: w_next = WR_HOLD;
         // The request that was just acknowledged must not start a second write.
         WR_HOLD:  w_next = w_rd_ok ? RD : IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rd_ptr    <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_next;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_remaining <= w_rem_nxt;
      end
   end

   // Strobes are decoded from the next state and registered, so they change
   // only on the clock edge and never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_cs_n   <= 1'b1;
         r_oe_n   <= 1'b1;
         r_we_n   <= 1'b1;
         r_wr_ack <= 1'b0;
         r_io_oe  <= 1'b0;
         r_io_dat <= '0;
      end else begin
         r_cs_n   <= (w_next == IDLE);
         r_oe_n   <= (w_next != RD);
         r_we_n   <= (w_next != WR_PULSE);
         r_wr_ack <= (w_next == WR_HOLD);
         r_io_oe  <= fb_is_wr_state(w_next);
         if (w_next == RD) begin
            r_a <= w_rd_ptr_nxt;
         end else if (w_next == WR_SETUP) begin
            r_a      <= bus.wr_addr;
            r_io_dat <= bus.wr_data;
         end
      end
   end

   assign io_sram_io    = r_io_oe ? r_io_dat : {DATA_W{1'bz}};

   assign bus.sram_a    = r_a;
   assign bus.sram_cs_n = r_cs_n;
   assign bus.sram_oe_n = r_oe_n;
   assign bus.sram_we_n = r_we_n;
   assign bus.wr_ack    = r_wr_ack;
   assign bus.pix_valid = w_fifo_vld;
   assign bus.pix_data  = w_fifo_dat;
   assign bus.line_busy = (r_remaining != '0);

endmodule

// File: tb/tb_fb_sram_master.sv
// Directed bench: behavioural async SRAM, scoreboard of expected scanout bytes, bus/FIFO monitors.
module tb_fb_sram_master;

   logic       clk;
   logic       rst_n;
   wire  [7:0] sram_io;

   logic [7:0] mem     [32768];
   logic [7:0] ref_mem [32768];
   logic [7:0] sb_q [$];

   int checks;
   int errors;
   int rd_cnt;
   int ack_cnt;
   int rx_cnt;

   fb_sram_master_if u_if ();

   fb_sram_master u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (u_if),
      .io_sram_io (sram_io)
   );

   assign sram_io = (!u_if.sram_cs_n && !u_if.sram_oe_n && u_if.sram_we_n) ?
                    mem[u_if.sram_a] : 8'bz;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // SRAM write capture, scoreboard compare and invariant checks, sampled mid-cycle.
   task automatic monitor();
      int occ;
      logic rd;
      logic pop;
      occ = 0;
      forever begin
         @(negedge clk);
         if (!u_if.sram_cs_n && !u_if.sram_we_n) mem[u_if.sram_a] = sram_io;
         if (!rst_n) begin
            occ = 0;
         end else begin
            rd  = !u_if.sram_cs_n && !u_if.sram_oe_n;
            pop = u_if.pix_valid && u_if.pix_rdy;
            if (!u_if.sram_cs_n)
               chk("bus_conflict", 32'({u_if.sram_oe_n, u_if.sram_we_n} != 2'b00), 32'd1);
            if (rd) rd_cnt++;
            if (u_if.wr_ack) ack_cnt++;
            if (pop) begin
               rx_cnt++;
               if (sb_q.size() == 0) chk("sb_unexpected_byte", 32'(sb_q.size() != 0), 32'd1);
               else                  chk("sb_data", 32'(u_if.pix_data), 32'(sb_q.pop_front()));
            end
            occ = u_if.line_start ? 0 : occ + int'(rd) - int'(pop);
            chk("fifo_overflow", 32'(occ <= 4), 32'd1);
         end
      end
   endtask

   task automatic start_line(input logic [14:0] base);
      logic [14:0] adr;
      @(posedge clk);
      #1;
      u_if.line_start = 1'b1;
      u_if.line_base  = base;
      @(posedge clk);
      sb_q.delete();
      for (int i = 0; i < 40; i++) begin
         adr = base + 15'(i);
         sb_q.push_back(ref_mem[adr]);
      end
      #1;
      u_if.line_start = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || u_if.line_busy || u_if.pix_valid) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 32'(sb_q.size() == 0 && !u_if.line_busy && !u_if.pix_valid), 32'd1);
   endtask

   task automatic do_write(input logic [14:0] addr, input logic [7:0] data, input logic toggle,
                           output int lat, output int we_lo, output int oe_lo, output logic busy);
      @(posedge clk);
      #1;
      u_if.wr_req  = 1'b1;
      u_if.wr_addr = addr;
      u_if.wr_data = data;
      ref_mem[addr] = data;
      lat = 0; we_lo = 0; oe_lo = 0; busy = 1'b0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (toggle) u_if.pix_rdy = ~u_if.pix_rdy;
         if (!u_if.sram_we_n) we_lo++;
         if (!u_if.sram_oe_n) oe_lo++;
         if (u_if.wr_ack) begin
            busy = u_if.line_busy;
            break;
         end
      end
      u_if.wr_req = 1'b0;
   endtask

   task automatic check_reset_state();
      chk("rst_cs_n",      32'(u_if.sram_cs_n), 32'd1);
      chk("rst_oe_n",      32'(u_if.sram_oe_n), 32'd1);
      chk("rst_we_n",      32'(u_if.sram_we_n), 32'd1);
      chk("rst_sram_a",    32'(u_if.sram_a),    32'd0);
      chk("rst_wr_ack",    32'(u_if.wr_ack),    32'd0);
      chk("rst_pix_valid", 32'(u_if.pix_valid), 32'd0);
      chk("rst_pix_data",  32'(u_if.pix_data),  32'd0);
      chk("rst_line_busy", 32'(u_if.line_busy), 32'd0);
   endtask

   initial begin
      int lat, we_lo, oe_lo, n, rd0, ack0, rx0;
      logic busy;
      logic [7:0] old_byte;

      checks = 0; errors = 0; rd_cnt = 0; ack_cnt = 0; rx_cnt = 0;
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = 8'(i);
         ref_mem[i] = 8'(i);
      end
      rst_n           = 1'b0;
      u_if.wr_req     = 1'b0;
      u_if.wr_addr    = '0;
      u_if.wr_data    = '0;
      u_if.line_start = 1'b0;
      u_if.line_base  = '0;
      u_if.pix_rdy    = 1'b1;
      fork
         monitor();
      join_none

      // Reset state, then a full line from 0x0100 streamed with no backpressure.
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state();
      rd0 = rd_cnt;
      start_line(15'h0100);
      drain("line1_drain");
      chk("line1_rd_count", 32'(rd_cnt - rd0), 32'd40);

      // Idle write: ack three cycles after request, single-cycle WE, OE never asserted.
      ack0 = ack_cnt;
      do_write(15'h0005, 8'hA5, 1'b0, lat, we_lo, oe_lo, busy);
      chk("wr_ack_latency", 32'(lat),   32'd3);
      chk("wr_we_low_cycles", 32'(we_lo), 32'd1);
      chk("wr_oe_low_cycles", 32'(oe_lo), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("wr_ack_pulses", 32'(ack_cnt - ack0), 32'd1);
      chk("wr_mem_0005", 32'(mem[15'h0005]), 32'hA5);

      // Backpressure: only FIFO_DEPTH reads issue, then the bus idles until drained.
      u_if.pix_rdy = 1'b0;
      rd0 = rd_cnt;
      start_line(15'h0000);
      repeat (20) @(posedge clk);
      #1;
      chk("bp_rd_count", 32'(rd_cnt - rd0), 32'd4);
      chk("bp_idle_cs_n", 32'(u_if.sram_cs_n), 32'd1);
      chk("bp_pix_valid", 32'(u_if.pix_valid), 32'd1);
      chk("bp_head_byte", 32'(u_if.pix_data), 32'h00);
      u_if.pix_rdy = 1'b1;
      drain("bp_drain");
      chk("bp_rd_total", 32'(rd_cnt - rd0), 32'd40);

      // Contention: a write held during a line with a slow consumer wins mid-line.
      ack0 = ack_cnt;
      start_line(15'h0200);
      do_write(15'h0300, 8'h3C, 1'b1, lat, we_lo, oe_lo, busy);
      chk("cont_ack_seen", 32'(lat < 100), 32'd1);
      chk("cont_mid_line", 32'(busy), 32'd1);
      chk("cont_we_low_cycles", 32'(we_lo), 32'd1);
      u_if.pix_rdy = 1'b1;
      drain("cont_drain");
      chk("cont_ack_pulses", 32'(ack_cnt - ack0), 32'd1);
      chk("cont_mem_0300", 32'(mem[15'h0300]), 32'h3C);

      // Address wrap at the top of memory, then a restart mid-line.
      rx0 = rx_cnt;
      start_line(15'h7FF0);
      n = 0;
      while (rx_cnt - rx0 < 20 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wrap_progress", 32'(rx_cnt - rx0 >= 20), 32'd1);
      start_line(15'h0400);
      rx0 = rx_cnt;
      drain("restart_drain");
      chk("restart_rx_count", 32'(rx_cnt - rx0), 32'd40);

      // Reset asserted while WE is low: strobes release at once, no ack, byte intact.
      old_byte = mem[15'h0010];
      ack0 = ack_cnt;
      @(posedge clk);
      #1;
      u_if.wr_req  = 1'b1;
      u_if.wr_addr = 15'h0010;
      u_if.wr_data = 8'h5A;
      n = 0;
      while (u_if.sram_we_n && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rstw_reached_pulse", 32'(u_if.sram_we_n), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw_we_n", 32'(u_if.sram_we_n), 32'd1);
      chk("rstw_cs_n", 32'(u_if.sram_cs_n), 32'd1);
      chk("rstw_ack",  32'(u_if.wr_ack),    32'd0);
      u_if.wr_req = 1'b0;
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      chk("rstw_no_ack", 32'(ack_cnt - ack0), 32'd0);
      chk("rstw_mem_intact", 32'(mem[15'h0010] == old_byte || mem[15'h0010] == 8'h5A), 32'd1);
      ref_mem[15'h0010] = mem[15'h0010];
      rst_n = 1'b1;
      rd0 = rd_cnt;
      start_line(15'h0008);
      drain("post_rst_drain");
      chk("post_rst_rd_count", 32'(rd_cnt - rd0), 32'd40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
